ysyx_22050243_ifu: RTL and testbench

Instruction fetch unit for the multi-cycle RV64 core. It directly feeds the decode/control stage.
- Holds the PC and issues one instruction-memory read at a time over a valid/ready request channel.
- Captures the 32-bit response and presents it, with its PC and pre-sliced opcode/funct3, to decode under a valid/ready handshake.
- Accepts redirects from branch/jump resolution and discards stale in-flight fetches.

---
 rtl/ysyx_22050243_ifu.sv | 125 ++++++++++++
 tb/tb_ysyx_22050243_ifu.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050243_ifu.sv
// Instruction fetch unit: holds the PC, issues one imem read at a time and
// hands the captured instruction to decode over a valid/ready handshake.
//
// state | meaning
// IDLE  | out of reset, one cycle before the first fetch
// REQ   | presenting pc on the request channel (or flagging a misaligned pc)
// WAIT  | request accepted, waiting for the response (drop marks it stale)
// HOLD  | instruction presented to decode until consumed or redirected
module ysyx_22050243_ifu #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  output logic            imem_rsp_ready,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [6:0]      inst_opcode,
  output logic [2:0]      inst_funct3,
  output logic            inst_fault
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic            drop_q;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] inst_pc_q;
  logic            fault_q;

  logic misaligned;
  logic req_fire;

  assign misaligned     = pc_q[1:0] != 2'b00;
  assign imem_req_valid = (state_q == S_REQ) && !misaligned;
  // Address is forced to zero outside REQ so every output reads 0 in reset.
  assign imem_req_addr  = (state_q == S_REQ) ? pc_q : '0;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign imem_rsp_ready = state_q == S_WAIT;
  assign inst_valid     = state_q == S_HOLD;

  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign inst_fault  = fault_q;
  assign inst_opcode = inst_q[6:0];
  assign inst_funct3 = inst_q[14:12];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      drop_q    <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (redirect_valid) pc_q <= redirect_pc;
          state_q <= S_REQ;
        end
        S_REQ: begin
          if (redirect_valid) begin
            pc_q <= redirect_pc;
            // An accepted request for the old pc must be waited out and discarded.
            if (req_fire) begin
              state_q <= S_WAIT;
              drop_q  <= 1'b1;
            end
          end else if (misaligned) begin
            state_q   <= S_HOLD;
            inst_q    <= '0;
            inst_pc_q <= pc_q;
            fault_q   <= 1'b1;
          end else if (req_fire) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            pc_q <= redirect_pc;
            if (imem_rsp_valid) begin
              drop_q  <= 1'b0;
              state_q <= S_REQ;
            end else begin
              drop_q <= 1'b1;
            end
          end else if (imem_rsp_valid) begin
            if (drop_q) begin
              drop_q  <= 1'b0;
              state_q <= S_REQ;
            end else begin
              inst_q    <= imem_rsp_err ? 32'h0 : imem_rsp_data;
              inst_pc_q <= pc_q;
              fault_q   <= imem_rsp_err;
              state_q   <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            pc_q    <= redirect_pc;
            state_q <= S_REQ;
          end else if (inst_ready) begin
            pc_q    <= pc_q + XLEN'(4);
            state_q <= S_REQ;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050243_ifu.sv
// Bench for ysyx_22050243_ifu: directed fetch scenarios with a latency-
// configurable memory responder and queue-based request/instruction checking.
module tb_ysyx_22050243_ifu;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic        imem_rsp_ready;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic [6:0]  inst_opcode;
  logic [2:0]  inst_funct3;
  logic        inst_fault;

  ysyx_22050243_ifu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_ready (imem_rsp_ready),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_opcode    (inst_opcode),
    .inst_funct3    (inst_funct3),
    .inst_fault     (inst_fault)
  );

  typedef struct {
    logic [31:0] d;
    logic [63:0] pc;
    logic        f;
  } inst_t;

  logic [63:0] exp_req[$];
  inst_t       exp_inst[$];
  int          checks = 0;
  int          errors = 0;
  int          mem_lat = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic [63:0] a);
    exp_req.push_back(a);
  endtask

  task automatic push_inst(input logic [31:0] d, input logic [63:0] pc, input logic f);
    inst_t e;
    e.d = d; e.pc = pc; e.f = f;
    exp_inst.push_back(e);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!inst_valid && n < 100) begin tick(); n++; end
    if (!inst_valid) begin
      checks++; errors++;
      $display("FAIL wait_inst_valid timeout actual=0 required=1");
    end
  endtask

  task automatic wait_rsp_ready();
    int n = 0;
    while (!imem_rsp_ready && n < 100) begin tick(); n++; end
    if (!imem_rsp_ready) begin
      checks++; errors++;
      $display("FAIL wait_rsp_ready timeout actual=0 required=1");
    end
  endtask

  task automatic consume();
    wait_valid();
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
  endtask

  task automatic consume_redirect(input logic [63:0] t);
    wait_valid();
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = t;
    tick();
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_valid"}, 64'(imem_req_valid), 64'h0);
    chk({tag, "_req_addr"},  imem_req_addr,        64'h0);
    chk({tag, "_rsp_ready"}, 64'(imem_rsp_ready), 64'h0);
    chk({tag, "_inst_valid"},64'(inst_valid),     64'h0);
    chk({tag, "_inst"},      64'(inst),           64'h0);
    chk({tag, "_inst_pc"},   inst_pc,             64'h0);
    chk({tag, "_fault"},     64'(inst_fault),     64'h0);
  endtask

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    case (a)
      64'h8000_0000: return 32'h0010_0513;
      64'h8000_0004: return 32'h0020_0593;
      64'h8000_0008: return 32'h00B5_0633;
      64'h8000_000C: return 32'hDEAD_BEEF;
      64'h8000_1000: return 32'h0000_A103;
      64'h8000_2000: return 32'h0000_8067;
      64'h8000_3000: return 32'h00B5_7533;
      64'h8000_3004: return 32'hFFFF_FFFF;
      default:       return 32'h0000_0013;
    endcase
  endfunction

  // Memory responder: one outstanding read, response after mem_lat idle cycles.
  initial begin
    logic        rq, rs, pend;
    logic [63:0] a, pa;
    int          cnt;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    pend = 1'b0; pa = '0; cnt = 0;
    forever begin
      @(posedge clk);
      rq = imem_req_valid && imem_req_ready;
      rs = imem_rsp_valid && imem_rsp_ready;
      a  = imem_req_addr;
      #1;
      if (!rst_n) begin
        pend = 1'b0;
        imem_rsp_valid = 1'b0;
      end else begin
        if (rs) begin
          imem_rsp_valid = 1'b0;
          pend = 1'b0;
        end
        if (rq) begin
          if (pend) begin
            checks++; errors++;
            $display("FAIL second_outstanding_req actual=1 required=0");
          end
          pend = 1'b1; pa = a; cnt = mem_lat;
        end
        if (pend && !imem_rsp_valid) begin
          if (cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data(pa);
            imem_rsp_err   = (pa == 64'h8000_3004);
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // Monitor: pops expectations on every handshake and checks hold stability.
  initial begin
    logic        p_stall, p_hold, p_redir, p_ready;
    logic [63:0] p_addr, p_pc, ea;
    logic [31:0] p_inst;
    inst_t       e;
    p_stall = 0; p_hold = 0; p_redir = 0; p_ready = 0;
    p_addr = '0; p_pc = '0; p_inst = '0;
    forever begin
      @(posedge clk);
      if (rst_n) begin
        if (imem_req_valid && imem_req_ready) begin
          if (exp_req.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_req actual=%h required=none", imem_req_addr);
          end else begin
            ea = exp_req.pop_front();
            chk("req_addr", imem_req_addr, ea);
          end
        end
        if (imem_rsp_valid && !imem_rsp_ready) begin
          checks++; errors++;
          $display("FAIL rsp_outside_wait actual=1 required=0");
        end
        if (p_stall && !p_redir && imem_req_valid)
          chk("req_addr_stable", imem_req_addr, p_addr);
        if (p_hold && !p_redir && !p_ready) begin
          chk("hold_valid", 64'(inst_valid), 64'h1);
          chk("hold_inst",  64'(inst), 64'(p_inst));
          chk("hold_pc",    inst_pc, p_pc);
        end
        if (inst_valid && inst_ready) begin
          if (exp_inst.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_inst actual=%h required=none", inst);
          end else begin
            e = exp_inst.pop_front();
            chk("inst",        64'(inst), 64'(e.d));
            chk("inst_pc",     inst_pc, e.pc);
            chk("inst_fault",  64'(inst_fault), 64'(e.f));
            chk("inst_opcode", 64'(inst_opcode), 64'(e.d[6:0]));
            chk("inst_funct3", 64'(inst_funct3), 64'(e.d[14:12]));
          end
        end
      end
      p_stall = rst_n && imem_req_valid && !imem_req_ready;
      p_hold  = rst_n && inst_valid;
      p_redir = redirect_valid;
      p_ready = inst_ready;
      p_addr  = imem_req_addr;
      p_pc    = inst_pc;
      p_inst  = inst;
    end
  end

  initial begin
    int n;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b0;
    repeat (2) tick();
    chk_all_zero("reset");

    // Basic fetch and latency out of reset
    push_req(64'h8000_0000);
    push_inst(32'h0010_0513, 64'h8000_0000, 1'b0);
    rst_n = 1'b1;
    n = 0;
    while (!inst_valid && n < 20) begin tick(); n++; end
    chk("first_latency", 64'(n), 64'd3);
    chk("first_opcode", 64'(inst_opcode), 64'h13);
    push_req(64'h8000_0004);
    push_inst(32'h0020_0593, 64'h8000_0004, 1'b0);
    consume();

    // Decode backpressure
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_inst_valid", 64'(inst_valid), 64'h1);
      chk("bp_req_valid", 64'(imem_req_valid), 64'h0);
    end
    mem_lat = 3;
    push_req(64'h8000_0008);
    push_inst(32'h00B5_0633, 64'h8000_0008, 1'b0);
    consume();

    // Stale response dropped after a redirect in WAIT
    push_req(64'h8000_000C);
    consume();
    wait_rsp_ready();
    push_req(64'h8000_1000);
    push_inst(32'h0000_A103, 64'h8000_1000, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1000;
    tick();
    redirect_valid = 1'b0;

    // Redirect together with consume
    wait_valid();
    mem_lat = 0;
    push_req(64'h8000_2000);
    push_inst(32'h0000_8067, 64'h8000_2000, 1'b0);
    consume_redirect(64'h8000_2000);

    // Memory backpressure, then redirect before acceptance
    wait_valid();
    imem_req_ready = 1'b0;
    push_req(64'h8000_3000);
    push_inst(32'h00B5_7533, 64'h8000_3000, 1'b0);
    consume();
    for (int i = 0; i < 3; i++) begin
      chk("stall_req_valid", 64'(imem_req_valid), 64'h1);
      chk("stall_req_addr", imem_req_addr, 64'h8000_2004);
      tick();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_3000;
    tick();
    redirect_valid = 1'b0;
    chk("redir_req_addr", imem_req_addr, 64'h8000_3000);
    imem_req_ready = 1'b1;

    // Access fault on the response
    wait_valid();
    push_req(64'h8000_3004);
    push_inst(32'h0, 64'h8000_3004, 1'b1);
    consume();

    // Misaligned redirect target: fault without a request
    wait_valid();
    push_inst(32'h0, 64'h8000_0002, 1'b1);
    consume_redirect(64'h8000_0002);
    wait_valid();
    chk("mis_fault", 64'(inst_fault), 64'h1);
    chk("mis_inst", 64'(inst), 64'h0);
    chk("mis_pc", inst_pc, 64'h8000_0002);

    // PC wrap-around at the top of the address space
    push_req(64'hFFFF_FFFF_FFFF_FFFC);
    push_inst(32'h0000_0013, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    consume_redirect(64'hFFFF_FFFF_FFFF_FFFC);
    wait_valid();
    push_req(64'h0);
    push_inst(32'h0000_0013, 64'h0, 1'b0);
    consume();

    // Asynchronous reset while a fetch is outstanding
    wait_valid();
    mem_lat = 5;
    push_req(64'h4);
    consume();
    wait_rsp_ready();
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    repeat (2) tick();
    mem_lat = 0;
    push_req(64'h8000_0000);
    push_inst(32'h0010_0513, 64'h8000_0000, 1'b0);
    push_req(64'h8000_0004);
    rst_n = 1'b1;
    consume();
    repeat (6) tick();
    chk("req_queue_drained", 64'(exp_req.size()), 64'h0);
    chk("inst_queue_drained", 64'(exp_inst.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
